instr_fetch: RTL
================

# instr_fetch

Instruction-fetch stage of the single-cycle MIPS datapath, directly upstream of the instruction controller. It holds the program counter and fetches one word per instruction over a request/acknowledge instruction-memory port. It presents the latched instruction and its decoded opcode/shamt/func fields to the controller. It then computes the next PC from the controller's `branch`/`jump` outputs and the ALU `zero` flag.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- `TIMEOUT`, 16: maximum cycles `imem_req` may stay high without `imem_ack` before a fetch error is declared.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address being fetched (= `pc`).
- `imem_ack`  in  1  read data valid this cycle; sampled only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  downstream hold; freezes the stage in EXEC.
- `branch`, `jump`, `zero`  in  1 each  from controller / ALU.
- `rs_data`  in  32  register rs value, used as the target for jr.
- `instr`  out  32  latched instruction.
- `opcode`  out  6  `instr[31:26]`.
- `shamt`  out  5  `instr[10:6]`.
- `func`  out  6  `instr[5:0]`.
- `instr_valid`  out  1  `instr` is valid for the controller this cycle.
- `pc`  out  32  address of current instruction.
- `pc_plus4`  out  32  `pc`+4, used as the jal link value.
- `fetch_err`  out  1  sticky timeout flag.
- `retired`  out  32  count of instructions completed.

## Operation
- The FSM has three states:
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`.
  - EXEC: `instr_valid`=1.
  - HALT: parked after a timeout.
- FETCH transitions:
  - Sampled `imem_ack`=1: latch `imem_rdata` into `instr`, go to EXEC.
  - Otherwise increment the wait counter.
  - Counter reaching `TIMEOUT`-1 without ack: set `fetch_err`, go to HALT.
- EXEC transitions:
  - `stall`=1: hold the state; `pc`, `instr` and `retired` are unchanged.
  - `stall`=0: load `pc` with next_pc, increment `retired` (wraps modulo 2^32), clear the wait counter, go to FETCH.
- next_pc is selected by priority, evaluated in EXEC:
  1. jr (`jump`=1, `opcode`=0, `func`=6'h08): next_pc = {`rs_data`[31:2], 2'b00}.
  2. j/jal (`jump`=1, `opcode` 6'h02 or 6'h03): next_pc = {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  3. Conditional branch (`branch`=1, `jump`=0, `zero`=1): next_pc = `pc_plus4` + (sign-extended `instr`[15:0] << 2). `zero` means the branch condition is true; the ALU produces it for both beq and bne.
  4. Otherwise next_pc = `pc_plus4`.
- All address arithmetic is 32-bit and wraps modulo 2^32. `pc` bits [1:0] are always 0.
- HALT is terminal until reset. In HALT: `imem_req`=0, `instr_valid`=0, all outputs frozen.
- `opcode`, `shamt` and `func` are combinational slices of `instr` and always track it.
- `instr_valid`=0 in FETCH and in HALT, and `imem_req`=0 in EXEC. Decode outputs are meaningful only when `instr_valid`=1.

## Timing
- Reset (sampled low at a rising edge) sets the following values:
  - state = FETCH, `pc` = `RESET_PC`.
  - `instr` = 32'h0 (nop), `retired` = 0.
  - `fetch_err` = 0, `instr_valid` = 0, wait counter = 0.
  - `imem_req` reads 1 from the first cycle after reset.
- Reset overrides every event in the same cycle, including `imem_ack`, `stall` and timeout.
- `imem_ack` may arrive in the first cycle of the request (zero-wait memory). Throughput is then 2 cycles per instruction; each wait cycle adds one.
- `imem_ack` with `imem_req`=0 is ignored.
- The PC update is visible, together with `imem_req`=1 at the new address, in the cycle after EXEC with `stall`=0.
- If `imem_ack` arrives in the same cycle the timeout expires, the ack wins: go to EXEC, no error.
- `stall` is ignored outside EXEC.

## Test plan
- **Reset:** reset, ack always immediate -> fetch addresses 0x0, 0x4, 0x8 on consecutive fetches; `retired` = 3 after 6 cycles.
- **Taken branch:** beq at 0x10 with offset 16'hFFFC, `branch`=1, `zero`=1 -> next fetch at 0x04. Same instruction with `zero`=0 -> next fetch at 0x14.
- **Jumps:**
  - j at 0x1000_0000 with `instr`[25:0] = 26'h40 -> next fetch at 0x1000_0100.
  - jr with `rs_data` = 0x0000_2003 -> next fetch at 0x0000_2000.
- **Stall:** ack delayed 3 cycles, then `stall` held 2 cycles in EXEC.
  - `instr_valid` stays high 3 cycles.
  - `pc` is unchanged until stall drops.
  - `retired` increments once.
- **Timeout:** no ack for `TIMEOUT`=16 cycles -> `fetch_err`=1 and `imem_req`=0 from cycle 17; ack arriving afterwards is ignored. Ack in cycle 16 -> no error.
- **Reset mid-fetch:** assert `rst_n`=0 in the same cycle as `imem_ack` -> `instr`=0, `pc`=`RESET_PC`, state FETCH.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and memory.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: holds the PC, fetches one word per instruction and
// computes the next PC from branch/jump/zero.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      imem,
  input  logic               stall,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  input  logic [31:0]        rs_data,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [4:0]         shamt,
  output logic [5:0]         func,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               fetch_err,
  output logic [31:0]        retired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WaitMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, instr_q, retired_q;
  logic [CntW-1:0] wait_q;
  logic            err_q;

  logic        ack_fire, timeout, advance;
  logic        is_jr, is_j, taken;
  logic [31:0] br_off, next_pc;

  assign ack_fire = (state_q == StFetch) && imem.imem_ack;
  assign timeout  = (state_q == StFetch) && !imem.imem_ack && (wait_q == WaitMax);
  assign advance  = (state_q == StExec) && !stall;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (imem.imem_ack)        state_d = StExec;
        else if (wait_q == WaitMax) state_d = StHalt;
      end
      StExec:  if (!stall) state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // FSM outputs
  always_comb begin
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;
    case (state_q)
      StFetch: imem.imem_req = 1'b1;
      StExec:  instr_valid   = 1'b1;
      default: ;
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign instr          = instr_q;
  assign opcode         = instr_q[31:26];
  assign shamt          = instr_q[10:6];
  assign func           = instr_q[5:0];
  assign fetch_err      = err_q;
  assign retired        = retired_q;

  assign is_jr  = jump && (opcode == 6'h00) && (func == 6'h08);
  assign is_j   = jump && ((opcode == 6'h02) || (opcode == 6'h03));
  assign taken  = branch && !jump && zero;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (is_jr)      next_pc = rs_data & 32'hFFFF_FFFC;
    else if (is_j)  next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (taken) next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= {RESET_PC[31:2], 2'b00};
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
      wait_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (ack_fire) instr_q <= imem.imem_rdata;
      // Counter freezes once the timeout fires; HALT never reads it again.
      if ((state_q == StFetch) && !imem.imem_ack && !timeout) wait_q <= wait_q + 1'b1;
      if (timeout) err_q <= 1'b1;
      if (advance) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 32'd1;
        wait_q    <= '0;
      end
    end
  end

endmodule
